// File: rtl/rob_multiport_pkg.sv
// rob_multiport_pkg
// Shared definitions for the multi-port reorder buffer:
//   - default geometry (depth, tag width, writeback ports, data width)
//   - destination register index width
//   - circular pointer increment for non power-of-two depths
package rob_multiport_pkg;

   localparam int ROB_DEPTH  = 15;
   localparam int ROB_TAG_W  = 4;
   localparam int ROB_NUM_WB = 2;
   localparam int ROB_XLEN   = 32;
   localparam int ROB_RD_W   = 5;

   // Advance a circular pointer, wrapping from depth-1 back to 0.
   function automatic int unsigned wrap_next(input int unsigned ptr, input int unsigned depth);
      return (ptr + 1 >= depth) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rob_multiport_if.sv
// rob_multiport_if
// Bundles the reorder buffer's dispatch, writeback, query and commit signals.
//   master : dispatch/execute/retire side (drives push, writeback, query, commit_ready)
//   slave  : the reorder buffer itself
// Signals:
//   push_valid/push_ready/push_addr/push_rd/push_tag : allocation handshake
//   wb_valid/wb_tag/wb_val                           : flattened NUM_WB writeback ports
//   flush                                            : mispredict clear
//   qry_tag/qry_hit/qry_val                          : operand forwarding lookup
//   commit_valid/commit_ready/commit_*               : in-order retirement
//   count                                            : occupancy
interface rob_multiport_if
   import rob_multiport_pkg::*;
#(
   parameter int TAG_W  = ROB_TAG_W,
   parameter int NUM_WB = ROB_NUM_WB,
   parameter int XLEN   = ROB_XLEN
);

   logic                     push_valid;
   logic                     push_ready;
   logic [XLEN-1:0]          push_addr;
   logic [ROB_RD_W-1:0]      push_rd;
   logic [TAG_W-1:0]         push_tag;

   logic [NUM_WB-1:0]        wb_valid;
   logic [NUM_WB*TAG_W-1:0]  wb_tag;
   logic [NUM_WB*XLEN-1:0]   wb_val;

   logic                     flush;

   logic [TAG_W-1:0]         qry_tag;
   logic                     qry_hit;
   logic [XLEN-1:0]          qry_val;

   logic                     commit_valid;
   logic                     commit_ready;
   logic [TAG_W-1:0]         commit_tag;
   logic [ROB_RD_W-1:0]      commit_rd;
   logic [XLEN-1:0]          commit_val;
   logic [XLEN-1:0]          commit_addr;

   logic [TAG_W:0]           count;

   modport master (
      output push_valid, push_addr, push_rd, wb_valid, wb_tag, wb_val,
             flush, qry_tag, commit_ready,
      input  push_ready, push_tag, qry_hit, qry_val, commit_valid,
             commit_tag, commit_rd, commit_val, commit_addr, count
   );

   modport slave (
      input  push_valid, push_addr, push_rd, wb_valid, wb_tag, wb_val,
             flush, qry_tag, commit_ready,
      output push_ready, push_tag, qry_hit, qry_val, commit_valid,
             commit_tag, commit_rd, commit_val, commit_addr, count
   );

endinterface

// File: rtl/rob_multiport_wb_select.sv
// rob_multiport_wb_select
// Combinational decode of all writeback ports against one tag.
// Ports:
//   wb_valid  : per-port strobe
//   wb_tag    : flattened port tags, port p at [p*TAG_W +: TAG_W]
//   wb_val    : flattened port values, port p at [p*XLEN +: XLEN]
//   match_tag : tag this instance watches (0 never matches)
//   hit       : some valid port carries match_tag
//   value     : value of the lowest-numbered matching port, 0 when no hit
// Entry acceptance (valid and not yet done) is applied by the caller; it is
// the same for every port aimed at one slot, so picking the lowest port here
// preserves lowest-port-wins after gating.
module rob_multiport_wb_select
   import rob_multiport_pkg::*;
#(
   parameter int TAG_W  = ROB_TAG_W,
   parameter int NUM_WB = ROB_NUM_WB,
   parameter int XLEN   = ROB_XLEN
) (
   input  logic [NUM_WB-1:0]       wb_valid,
   input  logic [NUM_WB*TAG_W-1:0] wb_tag,
   input  logic [NUM_WB*XLEN-1:0]  wb_val,
   input  logic [TAG_W-1:0]        match_tag,
   output logic                    hit,
   output logic [XLEN-1:0]         value
);

   // Scan from the highest port down so the lowest matching port is the last writer.
   always_comb begin
      hit   = 1'b0;
      value = '0;
      for (int p = NUM_WB - 1; p >= 0; p--) begin
         if (wb_valid[p] && (match_tag != '0) && (wb_tag[p*TAG_W +: TAG_W] == match_tag)) begin
            hit   = 1'b1;
            value = wb_val[p*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/rob_multiport.sv
// rob_multiport
// In-order reorder buffer with NUM_WB tag-addressed writeback ports.
// Ports:
//   clk_in   : clock
//   rst_n_in : synchronous active-low reset
//   rdy_in   : global enable; low freezes all state and blocks push/commit
//   bus      : rob_multiport_if slave (push, writeback, flush, query, commit, count)
// A tag is slot index + 1; tag 0 means "no producer".
module rob_multiport
   import rob_multiport_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int TAG_W  = ROB_TAG_W,
   parameter int NUM_WB = ROB_NUM_WB,
   parameter int XLEN   = ROB_XLEN
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            rdy_in,
   rob_multiport_if.slave  bus
);

   localparam int             PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

   logic                ent_valid [DEPTH];
   logic                ent_done  [DEPTH];
   logic [ROB_RD_W-1:0] ent_rd    [DEPTH];
   logic [XLEN-1:0]     ent_val   [DEPTH];
   logic [XLEN-1:0]     ent_addr  [DEPTH];

   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [TAG_W:0]      count;

   logic                slot_hit  [DEPTH];
   logic [XLEN-1:0]     slot_val  [DEPTH];

   logic                q_raw_hit;
   logic [XLEN-1:0]     q_raw_val;
   logic                q_in_range;
   logic [PTR_W-1:0]    q_slot;

   logic                push_fire;
   logic                pop_fire;
   logic                clear_all;

   // One decoder per slot, each watching its own fixed tag.
   for (genvar s = 0; s < DEPTH; s++) begin : g_slot
      rob_multiport_wb_select #(
         .TAG_W  (TAG_W),
         .NUM_WB (NUM_WB),
         .XLEN   (XLEN)
      ) u_sel (
         .wb_valid  (bus.wb_valid),
         .wb_tag    (bus.wb_tag),
         .wb_val    (bus.wb_val),
         .match_tag (TAG_W'(s + 1)),
         .hit       (slot_hit[s]),
         .value     (slot_val[s])
      );
   end

   // Extra decoder for the forwarding query bypass.
   rob_multiport_wb_select #(
      .TAG_W  (TAG_W),
      .NUM_WB (NUM_WB),
      .XLEN   (XLEN)
   ) u_qry_sel (
      .wb_valid  (bus.wb_valid),
      .wb_tag    (bus.wb_tag),
      .wb_val    (bus.wb_val),
      .match_tag (bus.qry_tag),
      .hit       (q_raw_hit),
      .value     (q_raw_val)
   );

   // Full stays full for a cycle even if the head retires, keeping push_ready
   // off the commit path.
   assign bus.push_ready   = rst_n_in & rdy_in & (count != FULL_COUNT);
   assign bus.push_tag     = TAG_W'(tail) + 1'b1;

   // Commit sees only registered done bits, so a writeback to the head is
   // visible to retirement one cycle later.
   assign bus.commit_valid = rst_n_in & rdy_in & ent_valid[head] & ent_done[head];
   assign bus.commit_tag   = TAG_W'(head) + 1'b1;
   assign bus.commit_rd    = ent_rd[head];
   assign bus.commit_val   = ent_val[head];
   assign bus.commit_addr  = ent_addr[head];
   assign bus.count        = count;

   assign push_fire = bus.push_valid & bus.push_ready;
   assign pop_fire  = bus.commit_valid & bus.commit_ready;
   assign clear_all = !rst_n_in || (rdy_in && bus.flush);

   // Forwarding: a same-cycle accepted writeback beats the stored value.
   always_comb begin
      q_in_range  = (bus.qry_tag != '0) && ({1'b0, bus.qry_tag} <= FULL_COUNT);
      q_slot      = q_in_range ? PTR_W'(bus.qry_tag - 1'b1) : '0;
      bus.qry_hit = 1'b0;
      bus.qry_val = '0;
      if (rst_n_in && q_in_range && ent_valid[q_slot]) begin
         if (q_raw_hit && !ent_done[q_slot]) begin
            bus.qry_hit = 1'b1;
            bus.qry_val = q_raw_val;
         end else if (ent_done[q_slot]) begin
            bus.qry_hit = 1'b1;
            bus.qry_val = ent_val[q_slot];
         end
      end
   end

   // Reset and flush share the clear path; push, writeback and pop are
   // concurrent and never collide (tail slot is invalid, head slot is done).
   always_ff @(posedge clk_in) begin
      if (clear_all) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int s = 0; s < DEPTH; s++) begin
            ent_valid[s] <= 1'b0;
            ent_done[s]  <= 1'b0;
            ent_rd[s]    <= '0;
            ent_val[s]   <= '0;
            ent_addr[s]  <= '0;
         end
      end else if (rdy_in) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (slot_hit[s] && ent_valid[s] && !ent_done[s]) begin
               ent_done[s] <= 1'b1;
               ent_val[s]  <= slot_val[s];
            end
         end
         if (pop_fire) begin
            ent_valid[head] <= 1'b0;
            ent_done[head]  <= 1'b0;
            ent_rd[head]    <= '0;
            ent_val[head]   <= '0;
            ent_addr[head]  <= '0;
            head            <= PTR_W'(wrap_next(32'(head), DEPTH));
         end
         if (push_fire) begin
            ent_valid[tail] <= 1'b1;
            ent_done[tail]  <= 1'b0;
            ent_rd[tail]    <= bus.push_rd;
            ent_val[tail]   <= '0;
            ent_addr[tail]  <= bus.push_addr;
            tail            <= PTR_W'(wrap_next(32'(tail), DEPTH));
         end
         count <= count + (TAG_W+1)'(push_fire) - (TAG_W+1)'(pop_fire);
      end
   end

endmodule
